// File: rtl/branch_update_queue_pkg.sv
// Shared types and sizes for the branch predictor update queue.
package branch_update_queue_pkg;

    localparam int unsigned PC_WIDTH            = 32;
    localparam int unsigned DEFAULT_QUEUE_WIDTH = 3;
    localparam int unsigned ENTRY_WIDTH         = PC_WIDTH + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                taken;
    } entry_t;

endpackage

// File: rtl/branch_update_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with a global freeze; reusable by commit-side buffers.
module branch_update_queue_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 33,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned COUNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = rdy && push && !full;
    assign do_pop  = rdy && pop && !empty;
    assign rdata   = mem[head];

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                head <= head + ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_update_queue.sv
// Buffers committed branch outcomes and drains one per cycle to the predictor update port.
module branch_update_queue
    import branch_update_queue_pkg::*;
#(
    parameter int unsigned QUEUE_WIDTH   = DEFAULT_QUEUE_WIDTH,
    parameter int unsigned QUEUE_SIZE    = 1 << QUEUE_WIDTH,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     commit_valid,
    input  logic [PC_WIDTH-1:0]      commit_pc,
    input  logic                     commit_taken,
    input  logic                     commit_predicted,
    output logic                     commit_ready,
    output logic                     update,
    output logic [PC_WIDTH-1:0]      update_pc,
    output logic                     update_result,
    output logic [COUNTER_WIDTH-1:0] branch_count,
    output logic [COUNTER_WIDTH-1:0] mispredict_count
);

    localparam int unsigned COUNT_W = QUEUE_WIDTH + 1;

    logic [QUEUE_WIDTH:0] count;
    logic                 empty;
    logic                 push;
    logic                 pop;
    entry_t               push_entry;
    entry_t               head_entry;

    // No look-ahead on a same-cycle pop: a full queue refuses commits.
    assign commit_ready = rdy && (count != COUNT_W'(QUEUE_SIZE));
    assign push         = commit_valid && commit_ready;
    assign pop          = rdy && !empty;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = commit_pc;
        push_entry.taken = commit_taken;
    end

    branch_update_queue_sync_fifo #(
        .DATA_WIDTH(ENTRY_WIDTH),
        .ADDR_WIDTH(QUEUE_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .push (push),
        .pop  (pop),
        .wdata(push_entry),
        .rdata(head_entry),
        .empty(empty),
        .count(count)
    );

    // Update strobe holds through a pause so the predictor consumes it exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update        <= 1'b0;
            update_pc     <= '0;
            update_result <= 1'b0;
        end else if (rdy) begin
            if (!empty) begin
                update        <= 1'b1;
                update_pc     <= head_entry.pc;
                update_result <= head_entry.taken;
            end else begin
                update <= 1'b0;
            end
        end
    end

    // Saturating performance counters, stepped only by accepted commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (push) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + COUNTER_WIDTH'(1);
            end
            if ((commit_taken != commit_predicted) && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Scoreboard bench for branch_update_queue: commit order, latency, pause, reset and saturation.
module tb_branch_update_queue;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          commit_taken;
    logic          commit_predicted;
    logic          commit_ready;
    logic          update;
    logic [31:0]   update_pc;
    logic          update_result;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [32:0] sb[$];
    int unsigned mb;
    int unsigned mm;

    branch_update_queue #(
        .QUEUE_WIDTH  (3),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_taken    (commit_taken),
        .commit_predicted(commit_predicted),
        .commit_ready    (commit_ready),
        .update          (update),
        .update_pc       (update_pc),
        .update_result   (update_result),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // A strobe seen here with rdy high is consumed by the predictor at the next edge.
    always @(negedge clk) begin
        if (rst && rdy && update) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {32'd0, update_pc}, 64'hFFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("strobe_pc", 64'(update_pc), 64'(e[32:1]));
                check("strobe_result", 64'(update_result), 64'(e[0]));
            end
        end
    end

    // Drives one commit for one edge; back-to-back calls give back-to-back commits.
    task automatic commit(input logic [31:0] pc, input logic taken, input logic pred);
        commit_valid     = 1'b1;
        commit_pc        = pc;
        commit_taken     = taken;
        commit_predicted = pred;
        check("commit_ready", 64'(commit_ready), 64'd1);
        sb.push_back({pc, taken});
        if (mb < 15) mb++;
        if ((taken != pred) && (mm < 15)) mm++;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || update) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
        check({tag, "_idle"}, 64'(update), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        mb = 0;
        mm = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(commit_ready), 64'd1);
        check("rst_update", 64'(update), 64'd0);
        check("rst_branch", 64'(branch_count), 64'd0);
        check("rst_mispred", 64'(mispredict_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mb = 0;
        mm = 0;
        rst = 1'b0;
        rdy = 1'b1;
        commit_valid = 1'b0;
        commit_pc = '0;
        commit_taken = 1'b0;
        commit_predicted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_update", 64'(update), 64'd0);
        check("por_pc", 64'(update_pc), 64'd0);
        check("por_branch", 64'(branch_count), 64'd0);
        rst = 1'b1;

        // Single branch: latency and one-cycle strobe.
        commit(32'h0000_1004, 1'b1, 1'b0);
        @(negedge clk);
        check("lat_n", 64'(update), 64'd0);
        check("cnt_branch1", 64'(branch_count), 64'd1);
        check("cnt_mispred1", 64'(mispredict_count), 64'd1);
        @(negedge clk);
        check("lat_n1_update", 64'(update), 64'd1);
        check("lat_n1_pc", 64'(update_pc), 64'h1004);
        check("lat_n1_result", 64'(update_result), 64'd1);
        @(negedge clk);
        check("lat_n2_update", 64'(update), 64'd0);
        check("lat_n2_pc_hold", 64'(update_pc), 64'h1004);
        drain("single_drain");

        // Burst of nine commits: never refused, emerges in order.
        do_reset();
        for (int i = 0; i < 9; i++) commit(32'(i * 4), 1'(i & 1), 1'b1);
        drain("burst_drain");
        check("burst_branch", 64'(branch_count), 64'(mb));
        check("burst_mispred", 64'(mispredict_count), 64'(mm));

        // Twenty back-to-back commits wrap the pointers twice.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            commit(32'h3000 + 32'(i * 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("stream_drain");
        check("stream_branch_sat", 64'(branch_count), 64'(mb));
        check("stream_mispred", 64'(mispredict_count), 64'(mm));

        // Pause with a strobe pending.
        do_reset();
        commit(32'h2000, 1'b1, 1'b1);
        commit(32'h2004, 1'b0, 1'b0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_update", 64'(update), 64'd1);
            check("pause_pc", 64'(update_pc), 64'h2000);
            check("pause_result", 64'(update_result), 64'd1);
            check("pause_ready", 64'(commit_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        @(negedge clk);
        check("resume_pc", 64'(update_pc), 64'h2000);
        @(negedge clk);
        check("resume_next_pc", 64'(update_pc), 64'h2004);
        drain("pause_drain");

        // Reset mid-operation discards everything in flight.
        for (int i = 0; i < 5; i++) commit(32'h500 + 32'(i * 4), 1'b1, 1'b0);
        do_reset();
        commit(32'h100, 1'b0, 1'b0);
        drain("post_rst_drain");
        check("post_rst_branch", 64'(branch_count), 64'd1);
        check("post_rst_mispred", 64'(mispredict_count), 64'd0);

        // Saturation of both counters.
        do_reset();
        for (int i = 0; i < 17; i++) commit(32'h4000 + 32'(i * 4), 1'b1, 1'b0);
        drain("sat_drain");
        check("sat_branch", 64'(branch_count), 64'hF);
        check("sat_mispred", 64'(mispredict_count), 64'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
